morse_key_decoder: RTL and testbench

//  Upstream stage of MorseToASCII. Times a single Morse key, classifies presses as dot/dash,

---
 rtl/morse_key_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// ---------------------------------------------------------------------------
// morse_key_decoder
//
// Times a single Morse key, classifies each press as a dot or a dash, finds
// letter and word gaps, and emits a 6-bit character index with a one-cycle
// strobe. Index map: 0-9 digits, 10-35 letters A-Z, 36 word space.
// Patterns that are unmapped or longer than five symbols raise "invalid".
//
// Ports
//   clock       in   1  system clock
//   reset       in   1  asynchronous reset, active low
//   key         in   1  debounced key, 1 = pressed, asynchronous to clock
//   morse       out  6  character index, valid while morseReady is high
//   morseReady  out  1  one-cycle strobe: morse holds a new character
//   invalid     out  1  one-cycle strobe: completed pattern was rejected
//   symCount    out  3  symbols captured in the current letter (6 = overflow)
// ---------------------------------------------------------------------------
module morse_key_decoder #(
    parameter int UNIT_CYCLES = 6000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] morse,
    output logic       morseReady,
    output logic       invalid,
    output logic [2:0] symCount
);

    localparam int CW = $clog2(5 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] LETTER_CNT = CW'(2 * UNIT_CYCLES);
    localparam logic [CW-1:0] WORD_CNT   = CW'(5 * UNIT_CYCLES);
    localparam logic [5:0]    SPACE_IDX  = 6'd36;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WORDWAIT
    } state_t;

    logic          keyMeta_q;
    logic          keyS_q;
    logic          keyPrev_q;
    logic [1:0]    syncFill_q;
    logic          armed_q;
    logic          keyRise;
    logic          keyFall;
    logic          keyEdge;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    pattern_q, pattern_d;
    logic [2:0]    len_q, len_d;
    logic          spacePending_q, spacePending_d;
    logic [5:0]    morse_q, morse_d;
    logic          morseReady_q, morseReady_d;
    logic          invalid_q, invalid_d;
    logic [6:0]    charInfo;

    // ITU table. Symbols enter at bit 0, so the first symbol sits at bit
    // len-1. Returns {found, index}.
    function automatic logic [6:0] lookupChar(input logic [2:0] len,
                                              input logic [4:0] pat);
        logic [6:0] res;
        res = 7'd0;
        case ({len, pat})
            {3'd1, 5'b00000}: res = {1'b1, 6'd14};  // E
            {3'd1, 5'b00001}: res = {1'b1, 6'd29};  // T
            {3'd2, 5'b00001}: res = {1'b1, 6'd10};  // A
            {3'd2, 5'b00000}: res = {1'b1, 6'd18};  // I
            {3'd2, 5'b00011}: res = {1'b1, 6'd22};  // M
            {3'd2, 5'b00010}: res = {1'b1, 6'd23};  // N
            {3'd3, 5'b00100}: res = {1'b1, 6'd13};  // D
            {3'd3, 5'b00110}: res = {1'b1, 6'd16};  // G
            {3'd3, 5'b00101}: res = {1'b1, 6'd20};  // K
            {3'd3, 5'b00111}: res = {1'b1, 6'd24};  // O
            {3'd3, 5'b00010}: res = {1'b1, 6'd27};  // R
            {3'd3, 5'b00000}: res = {1'b1, 6'd28};  // S
            {3'd3, 5'b00001}: res = {1'b1, 6'd30};  // U
            {3'd3, 5'b00011}: res = {1'b1, 6'd32};  // W
            {3'd4, 5'b01000}: res = {1'b1, 6'd11};  // B
            {3'd4, 5'b01010}: res = {1'b1, 6'd12};  // C
            {3'd4, 5'b00010}: res = {1'b1, 6'd15};  // F
            {3'd4, 5'b00000}: res = {1'b1, 6'd17};  // H
            {3'd4, 5'b00111}: res = {1'b1, 6'd19};  // J
            {3'd4, 5'b00100}: res = {1'b1, 6'd21};  // L
            {3'd4, 5'b00110}: res = {1'b1, 6'd25};  // P
            {3'd4, 5'b01101}: res = {1'b1, 6'd26};  // Q
            {3'd4, 5'b00001}: res = {1'b1, 6'd31};  // V
            {3'd4, 5'b01001}: res = {1'b1, 6'd33};  // X
            {3'd4, 5'b01011}: res = {1'b1, 6'd34};  // Y
            {3'd4, 5'b01100}: res = {1'b1, 6'd35};  // Z
            {3'd5, 5'b11111}: res = {1'b1, 6'd0};
            {3'd5, 5'b01111}: res = {1'b1, 6'd1};
            {3'd5, 5'b00111}: res = {1'b1, 6'd2};
            {3'd5, 5'b00011}: res = {1'b1, 6'd3};
            {3'd5, 5'b00001}: res = {1'b1, 6'd4};
            {3'd5, 5'b00000}: res = {1'b1, 6'd5};
            {3'd5, 5'b10000}: res = {1'b1, 6'd6};
            {3'd5, 5'b11000}: res = {1'b1, 6'd7};
            {3'd5, 5'b11100}: res = {1'b1, 6'd8};
            {3'd5, 5'b11110}: res = {1'b1, 6'd9};
            default:          res = 7'd0;
        endcase
        return res;
    endfunction

    // Two-flop synchroniser plus edge-detect copy. syncFill_q marks when
    // keyS_q holds a genuine post-reset sample; armed_q only sets once the
    // key has been seen released, so a key held through reset is ignored
    // until it is let go and pressed again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keyMeta_q  <= 1'b0;
            keyS_q     <= 1'b0;
            keyPrev_q  <= 1'b0;
            syncFill_q <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            keyMeta_q  <= key;
            keyS_q     <= keyMeta_q;
            keyPrev_q  <= keyS_q;
            syncFill_q <= {syncFill_q[0], 1'b1};
            armed_q    <= armed_q | (syncFill_q[1] & ~keyS_q);
        end
    end

    assign keyRise  = keyS_q & ~keyPrev_q & armed_q;
    assign keyFall  = ~keyS_q & keyPrev_q;
    assign keyEdge  = keyS_q ^ keyPrev_q;
    assign charInfo = lookupChar(len_q, pattern_q);

    // State, timing and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            pattern_q      <= 5'd0;
            len_q          <= 3'd0;
            spacePending_q <= 1'b0;
            morse_q        <= 6'd0;
            morseReady_q   <= 1'b0;
            invalid_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            spacePending_q <= spacePending_d;
            morse_q        <= morse_d;
            morseReady_q   <= morseReady_d;
            invalid_q      <= invalid_d;
        end
    end

    // Next-state logic. The edge cycle itself loads 1 into the counter, so
    // when the opposite edge arrives count_q equals the number of clocks
    // key_s spent at its level. The counter is not restarted at letter end:
    // the word gap is measured from the release, like the letter gap.
    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        len_d          = len_q;
        spacePending_d = spacePending_q;
        morse_d        = morse_q;
        morseReady_d   = 1'b0;
        invalid_d      = 1'b0;

        if (keyEdge) begin
            count_d = CW'(1);
        end else if (count_q == WORD_CNT) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (keyRise) begin
                    state_d = PRESS;
                end
            end

            PRESS: begin
                if (keyFall) begin
                    state_d = GAP;
                    if (len_q < 3'd5) begin
                        pattern_d = {pattern_q[3:0], (count_q >= LETTER_CNT)};
                    end
                    if (len_q < 3'd6) begin
                        len_d = len_q + 3'd1;
                    end
                end
            end

            // A rise on the threshold cycle still closes the letter first;
            // the new letter's first symbol is captured later at its fall.
            GAP: begin
                if (count_q == LETTER_CNT) begin
                    state_d   = WORDWAIT;
                    pattern_d = 5'd0;
                    len_d     = 3'd0;
                    if (len_q <= 3'd5 && charInfo[6]) begin
                        morse_d        = charInfo[5:0];
                        morseReady_d   = 1'b1;
                        spacePending_d = 1'b1;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
                if (keyRise) begin
                    state_d = PRESS;
                end
            end

            WORDWAIT: begin
                if (keyRise) begin
                    state_d = PRESS;
                end else if (count_q == WORD_CNT) begin
                    state_d = IDLE;
                    if (spacePending_q) begin
                        morse_d        = SPACE_IDX;
                        morseReady_d   = 1'b1;
                        spacePending_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign morse      = morse_q;
    assign morseReady = morseReady_q;
    assign invalid    = invalid_q;
    assign symCount   = len_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_key_decoder
//
// Drives the key on falling clock edges and records every strobe (kind,
// index, cycle) from the DUT. A reference model works purely on key
// timing: each press is a dot or dash by its length, each low interval
// closes a letter if it is at least two units long and emits a word space
// if it exceeds five units, with strobes landing three clocks after the
// corresponding threshold measured from the release at the pin.
// ---------------------------------------------------------------------------
module tb_morse_key_decoder;

    localparam int UNIT       = 4;
    localparam int LETTER_GAP = 2 * UNIT;
    localparam int WORD_GAP   = 5 * UNIT;
    localparam int LATENCY    = 3;

    typedef struct {
        int kind;
        int value;
        int cycle;
    } event_t;

    logic       clock;
    logic       reset;
    logic       key;
    logic [5:0] morse;
    logic       morseReady;
    logic       invalid;
    logic [2:0] symCount;

    event_t obsQ[$];
    event_t expQ[$];
    event_t monEv;
    int     cycleCnt  = 0;
    int     checks    = 0;
    int     errors    = 0;
    int     bothHigh  = 0;
    string  modelPat  = "";
    bit     modelPending = 1'b0;
    string  dotStr    = ".";
    string  dashStr   = "-";
    string  itu [36]  = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----.",
                          ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                          "....", "..", ".---", "-.-", ".-..", "--", "-.",
                          "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                          "...-", ".--", "-..-", "-.--", "--.."};

    morse_key_decoder #(.UNIT_CYCLES(UNIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .key        (key),
        .morse      (morse),
        .morseReady (morseReady),
        .invalid    (invalid),
        .symCount   (symCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle number, advanced on every active edge.
    always @(posedge clock) cycleCnt++;

    // Strobe recorder, sampled on the inactive edge.
    always @(negedge clock) begin
        if (morseReady === 1'b1 && invalid === 1'b1) bothHigh++;
        if (morseReady === 1'b1) begin
            monEv.kind  = 0;
            monEv.value = int'(morse);
            monEv.cycle = cycleCnt;
            obsQ.push_back(monEv);
        end else if (invalid === 1'b1) begin
            monEv.kind  = 1;
            monEv.value = 0;
            monEv.cycle = cycleCnt;
            obsQ.push_back(monEv);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int lookupModel(input string pat);
        for (int i = 0; i < 36; i++) begin
            if (itu[i] == pat) return i;
        end
        return -1;
    endfunction

    task automatic pushExpected(input int kind, input int value, input int cycle);
        event_t e;
        e.kind  = kind;
        e.value = value;
        e.cycle = cycle;
        expQ.push_back(e);
    endtask

    // Letter end as seen by the model: a strobe 2 units + latency after the
    // release, either a character or a rejection.
    task automatic modelLetterEnd(input int fall);
        int idx;
        idx = lookupModel(modelPat);
        if (modelPat.len() <= 5 && idx >= 0) begin
            pushExpected(0, idx, fall + LETTER_GAP + LATENCY);
            modelPending = 1'b1;
        end else begin
            pushExpected(1, 0, fall + LETTER_GAP + LATENCY);
        end
        modelPat = "";
    endtask

    // level=1: hold the key for n clocks (one symbol).
    // level=0: release for n clocks (one gap); the model resolves the gap.
    task automatic applyStimulus(input logic level, input int n);
        int fall;
        int expectLen;
        bit hadLetter;
        if (level) begin
            key = 1'b1;
            repeat (n) @(negedge clock);
            modelPat = {modelPat, (n >= LETTER_GAP) ? dashStr : dotStr};
        end else begin
            fall      = cycleCnt;
            hadLetter = (modelPat.len() > 0);
            expectLen = (modelPat.len() > 6) ? 6 : modelPat.len();
            key = 1'b0;
            if (hadLetter && n >= LETTER_GAP) begin
                modelLetterEnd(fall);
                if (n > WORD_GAP && modelPending) begin
                    pushExpected(0, 36, fall + WORD_GAP + LATENCY);
                    modelPending = 1'b0;
                end
            end
            repeat (n) @(negedge clock);
            if (hadLetter && n >= 3 && n < LETTER_GAP) begin
                checkOutput("symCount", {29'd0, symCount}, expectLen);
            end else if (hadLetter && n >= LETTER_GAP + 4) begin
                checkOutput("symCountCleared", {29'd0, symCount}, 0);
            end
        end
    endtask

    task automatic applyReset(input int n);
        reset = 1'b0;
        modelPat     = "";
        modelPending = 1'b0;
        @(negedge clock);
        checkOutput("rst.morse", {26'd0, morse}, 0);
        checkOutput("rst.morseReady", {31'd0, morseReady}, 0);
        checkOutput("rst.invalid", {31'd0, invalid}, 0);
        checkOutput("rst.symCount", {29'd0, symCount}, 0);
        repeat (n - 1) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic compareEvents(input string tag);
        int n;
        checkOutput({tag, ".count"}, obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d].kind", tag, i), obsQ[i].kind, expQ[i].kind);
            checkOutput($sformatf("%s[%0d].value", tag, i), obsQ[i].value, expQ[i].value);
            checkOutput($sformatf("%s[%0d].cycle", tag, i), obsQ[i].cycle, expQ[i].cycle);
        end
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        int    fallRef;
        int    nsym;
        int    gap;
        string s;

        key   = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset.morse", {26'd0, morse}, 0);
        checkOutput("reset.morseReady", {31'd0, morseReady}, 0);
        checkOutput("reset.invalid", {31'd0, invalid}, 0);
        checkOutput("reset.symCount", {29'd0, symCount}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // A: dot, dash, then a long release.
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 12);
        fallRef = cycleCnt;
        applyStimulus(1'b0, 30);
        checkOutput("A.latency", (obsQ.size() > 0) ? obsQ[0].cycle - fallRef : -1, 11);
        checkOutput("A.value", (obsQ.size() > 0) ? obsQ[0].value : -1, 10);
        compareEvents("A");

        // Every ITU pattern, 8-clock gap between letters.
        for (int i = 0; i < 36; i++) begin
            s = itu[i];
            for (int k = 0; k < s.len(); k++) begin
                applyStimulus(1'b1, (s.getc(k) == "-") ? 12 : 4);
                if (k < s.len() - 1) applyStimulus(1'b0, 4);
                else applyStimulus(1'b0, (i == 35) ? 30 : 8);
            end
        end
        for (int i = 0; i < 36; i++) begin
            checkOutput($sformatf("table[%0d]", i), (obsQ.size() > i) ? obsQ[i].value : -1, i);
        end
        compareEvents("table");

        // E followed by a long idle: letter, then one space 12 clocks later.
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 65);
        checkOutput("E.strobes", obsQ.size(), 2);
        checkOutput("E.spaceDelay", (obsQ.size() > 1) ? obsQ[1].cycle - obsQ[0].cycle : -1, 12);
        checkOutput("E.space", (obsQ.size() > 1) ? obsQ[1].value : -1, 36);
        compareEvents("E");

        // Overflow (six dots) then unmapped ..--
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4);
            applyStimulus(1'b0, (k == 5) ? 30 : 4);
        end
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 30);
        checkOutput("invalid.kind0", (obsQ.size() > 0) ? obsQ[0].kind : -1, 1);
        checkOutput("invalid.kind1", (obsQ.size() > 1) ? obsQ[1].kind : -1, 1);
        compareEvents("invalid");

        // Dot/dash threshold.
        applyStimulus(1'b1, 7);
        applyStimulus(1'b0, 30);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 30);
        checkOutput("press7", (obsQ.size() > 0) ? obsQ[0].value : -1, 14);
        checkOutput("press8", (obsQ.size() > 2) ? obsQ[2].value : -1, 29);
        compareEvents("threshold");

        // Reset after three dots discards them; a dash then decodes as T.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4);
            applyStimulus(1'b0, 4);
        end
        applyReset(3);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 30);
        checkOutput("resetMid.T", (obsQ.size() > 0) ? obsQ[0].value : -1, 29);
        compareEvents("resetMid");

        // Key held through reset must be ignored until pressed again.
        key = 1'b1;
        repeat (6) @(negedge clock);
        applyReset(3);
        repeat (20) @(negedge clock);
        checkOutput("heldKey.symCount", {29'd0, symCount}, 0);
        key = 1'b0;
        repeat (10) @(negedge clock);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 30);
        compareEvents("heldKey");

        // Random letters with random press and gap lengths.
        for (int l = 0; l < 40; l++) begin
            nsym = $urandom_range(1, 6);
            for (int k = 0; k < nsym; k++) begin
                applyStimulus(1'b1, ($urandom_range(0, 1) == 1) ? $urandom_range(8, 22)
                                                                 : $urandom_range(1, 7));
                if (k < nsym - 1) gap = $urandom_range(1, 7);
                else gap = (l == 39) ? 30 : $urandom_range(8, 30);
                applyStimulus(1'b0, gap);
            end
        end
        compareEvents("random");

        checkOutput("exclusiveStrobes", bothHigh, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
